// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline latch: default bubble word,
// latch state encoding and channel index constants.
package pipe_pkg;

   // Instruction word loaded into channel 0 for bubbles, reset and flush.
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   // Channel indices inside the packed data bus.
   localparam int CH_IR = 0;
   localparam int CH_PC = 1;

   // EMPTY: no live instruction; FULL: main register live;
   // SKID: main and skid both live (only reachable with the skid buffer).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } latch_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry holding register with a valid flag. It parks one item
// while the downstream stage is stalled.
module pipe_skid_buf #(
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic             pop,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;

   // Valid flag: set on load, dropped on pop, flush or reset.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         valid_reg <= 1'b0;
      end else if (load) begin
         valid_reg <= 1'b1;
      end else if (pop) begin
         valid_reg <= 1'b0;
      end
   end

   // Payload: captured on load; zeroed on reset so it is never X.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_reg <= '0;
      end else if (load) begin
         data_reg <= load_data;
      end
   end

   assign data  = data_reg;
   assign valid = valid_reg;

endmodule

// File: rtl/pipe_latch.sv
// Parametrised inter-stage pipeline latch with valid/ready handshake,
// flush-to-bubble and a saturating stall counter.
// Build option: PIPE_LATCH_SKID_EN adds a skid entry so in_ready is
// driven from a register only (no combinational path from out_ready).
module pipe_latch
   import pipe_pkg::*;
#(
   parameter int              DATA_W   = 32,
   parameter int              NUM_CH   = 2,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
   parameter int              CNT_W    = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]         stall_cnt
);

   localparam int BUS_W = NUM_CH * DATA_W;

   logic [BUS_W-1:0] bubble_data;
   logic [BUS_W-1:0] main_reg, main_next;
   latch_state_t     state_reg, state_next;
   logic [CNT_W-1:0] stall_reg;

   // Bubble: NOP in the instruction channel, zeros everywhere else.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bubble
         if (gi == CH_IR) begin : g_ir
            assign bubble_data[gi*DATA_W +: DATA_W] = NOP_WORD;
         end else begin : g_zero
            assign bubble_data[gi*DATA_W +: DATA_W] = '0;
         end
      end
   endgenerate

   assign out_valid = (state_reg != EMPTY);
   assign out_data  = main_reg;

`ifdef PIPE_LATCH_SKID_EN
   logic             skid_load;
   logic             skid_pop;
   logic             skid_valid;
   logic [BUS_W-1:0] skid_data;

   pipe_skid_buf #(
      .WIDTH(BUS_W)
   ) u_skid (
      .clock    (clock),
      .reset    (reset),
      .clear    (flush),
      .load     (skid_load),
      .pop      (skid_pop),
      .load_data(in_data),
      .data     (skid_data),
      .valid    (skid_valid)
   );

   // Accept whenever the skid slot is free; purely registered.
   assign in_ready = ~skid_valid;

   // Next state: refill main from input or skid; park input in skid on stall.
   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_load  = 1'b0;
      skid_pop   = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (in_valid) begin
               state_next = FULL;
               main_next  = in_data;
            end
         end
         FULL: begin
            if (out_ready) begin
               if (in_valid) begin
                  main_next = in_data;
               end else begin
                  state_next = EMPTY;
                  main_next  = bubble_data;
               end
            end else if (in_valid) begin
               skid_load  = 1'b1;
               state_next = SKID;
            end
         end
         SKID: begin
            if (out_ready) begin
               main_next  = skid_data;
               skid_pop   = 1'b1;
               state_next = FULL;
            end
         end
         default: begin
            state_next = EMPTY;
            main_next  = bubble_data;
         end
      endcase
      // Flush squashes main and the skid entry, dropping any same-cycle input.
      if (flush) begin
         state_next = EMPTY;
         main_next  = bubble_data;
         skid_load  = 1'b0;
         skid_pop   = 1'b0;
      end
   end
`else
   // Accept when empty or when the current item leaves this cycle.
   assign in_ready = ~out_valid | out_ready;

   // Next state: load input or a bubble whenever the latch can advance.
   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      if (in_ready) begin
         if (in_valid) begin
            state_next = FULL;
            main_next  = in_data;
         end else begin
            state_next = EMPTY;
            main_next  = bubble_data;
         end
      end
      if (flush) begin
         state_next = EMPTY;
         main_next  = bubble_data;
      end
   end
`endif

   // State and main data register; reset loads a bubble.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= EMPTY;
         main_reg  <= bubble_data;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
      end
   end

   // Stall counter: counts blocked output cycles, saturates, survives flush.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_reg <= '0;
      end else if (out_valid && !out_ready && (stall_reg != {CNT_W{1'b1}})) begin
         stall_reg <= stall_reg + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_pipe_latch.sv
// Self-checking bench for pipe_latch: directed cycle checks plus a
// queue scoreboard of every accepted item against every delivered item.
module tb_pipe_latch;
   import pipe_pkg::*;

   localparam int          DATA_W = 32;
   localparam int          NUM_CH = 2;
   localparam int          CNT_W  = 4;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [63:0] BUBBLE = {32'h0000_0000, NOP};

`ifdef PIPE_LATCH_SKID_EN
   localparam logic EXP_READY_STALL1 = 1'b1;
`else
   localparam logic EXP_READY_STALL1 = 1'b0;
`endif

   logic        clock     = 1'b0;
   logic        reset     = 1'b1;
   logic        flush     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] in_data   = '0;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] out_data;
   logic [3:0]  stall_cnt;

   int          checks    = 0;
   int          errors    = 0;
   int          out_count = 0;
   logic [63:0] sb[$];
   logic [63:0] sb_exp;

   pipe_latch #(
      .DATA_W  (DATA_W),
      .NUM_CH  (NUM_CH),
      .NOP_WORD(NOP),
      .CNT_W   (CNT_W)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .stall_cnt(stall_cnt)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [31:0] pc, input logic [31:0] ir);
      logic [63:0] v;
      v[CH_PC*DATA_W +: DATA_W] = pc;
      v[CH_IR*DATA_W +: DATA_W] = ir;
      return v;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard: pop on transfer-out, then push on transfer-in; flush/reset squash.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            sb_exp = sb.pop_front();
            check_val("sb_data", out_data, sb_exp);
            out_count++;
            $display("OUT %0d data %h", out_count, out_data);
         end
      end
      if (reset || flush) begin
         sb.delete();
      end else if (in_valid && in_ready) begin
         sb.push_back(in_data);
      end
   end

   initial begin
      // Reset held for two cycles.
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check_val("rst_valid", 64'(out_valid), 64'd0);
      check_val("rst_data", out_data, BUBBLE);
      check_val("rst_stall", 64'(stall_cnt), 64'd0);
      check_val("rst_ready", 64'(in_ready), 64'd1);

      // Streaming: first item visible after one cycle, then 10 back-to-back.
      in_data   = mk(32'h4, 32'h2002_0001);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      check_val("lat_valid", 64'(out_valid), 64'd1);
      check_val("lat_data", out_data, mk(32'h4, 32'h2002_0001));
      for (int i = 0; i < 10; i++) begin
         in_data = mk(32'h8 + 32'(4 * i), 32'h1000_0000 + 32'(i));
         tick();
      end
      in_valid = 1'b0;
      tick();
      // Idle with downstream ready loads a bubble.
      check_val("idle_valid", 64'(out_valid), 64'd0);
      check_val("idle_data", out_data, BUBBLE);
      tick();
      check_val("stream_count", 64'(out_count), 64'd11);
      check_val("stream_sb_empty", 64'(sb.size()), 64'd0);

      // Stall for five cycles with data held.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      in_data   = mk(32'h100, 32'hAAAA_0001);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      check_val("stall_load_data", out_data, mk(32'h100, 32'hAAAA_0001));
      check_val("stall_ready_first", 64'(in_ready), 64'(EXP_READY_STALL1));
      in_data = mk(32'h104, 32'hBBBB_0002);
      repeat (5) tick();
      check_val("stall_hold_data", out_data, mk(32'h100, 32'hAAAA_0001));
      check_val("stall_cnt5", 64'(stall_cnt), 64'd5);
      check_val("stall_ready", 64'(in_ready), 64'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      check_val("stall_cnt_kept", 64'(stall_cnt), 64'd5);
      check_val("stall_sb_empty", 64'(sb.size()), 64'd0);

      // Flush with a same-cycle input: everything squashed, next input passes.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = mk(32'h200, 32'hCCCC_0001);
      tick();
      in_data = mk(32'h204, 32'hCCCC_0002);
      tick();
      flush   = 1'b1;
      in_data = mk(32'h208, 32'hDDDD_0003);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check_val("flush_valid", 64'(out_valid), 64'd0);
      check_val("flush_data", out_data, BUBBLE);
      check_val("flush_ready", 64'(in_ready), 64'd1);
      check_val("flush_stall", 64'(stall_cnt), 64'd7);
      in_data   = mk(32'h300, 32'hEEEE_0004);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check_val("post_flush_valid", 64'(out_valid), 64'd1);
      check_val("post_flush_data", out_data, mk(32'h300, 32'hEEEE_0004));
      tick();
      check_val("flush_sb_empty", 64'(sb.size()), 64'd0);

      // Saturation of the 4-bit stall counter.
      in_data   = mk(32'h400, 32'hFFFF_0005);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (20) tick();
      check_val("sat_cnt", 64'(stall_cnt), 64'd15);
      repeat (2) tick();
      check_val("sat_hold", 64'(stall_cnt), 64'd15);
      check_val("sat_data", out_data, mk(32'h400, 32'hFFFF_0005));

      // Reset mid-operation behaves like flush and clears the counter.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("mid_rst_valid", 64'(out_valid), 64'd0);
      check_val("mid_rst_data", out_data, BUBBLE);
      check_val("mid_rst_stall", 64'(stall_cnt), 64'd0);
      check_val("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
